// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Digit codes, anode patterns, slot and conversion-state encodings.
package display_pkg;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [2:0] AN_UNITS = 3'b110;
  localparam logic [2:0] AN_TENS  = 3'b101;
  localparam logic [2:0] AN_SIGN  = 3'b011;

  typedef enum logic [1:0] {
    SLOT_UNITS,
    SLOT_TENS,
    SLOT_SIGN
  } slot_e;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CONV
  } conv_state_e;

  // -16 maps to 16: the negate wraps in 5 bits and is read unsigned
  function automatic logic [4:0] abs_mag(
    input logic [4:0] v,
    input logic       sm
  );
    return (sm && v[4]) ? 5'(~v + 5'd1) : v;
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Value handshake between the value source and the scan controller.
// The source is master; the controller is slave.
interface display_scan_if;
  logic       value_valid;
  logic       value_ready;
  logic [4:0] value;
  logic       signed_mode;

  modport master (
    output value_valid,
    output value,
    output signed_mode,
    input  value_ready
  );

  modport slave (
    input  value_valid,
    input  value,
    input  signed_mode,
    output value_ready
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 5-bit to tens/units converter by repeated subtraction.
// done_o marks the cycle whose edge holds the final result.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [4:0] value_i,
  input  logic       signed_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       neg_o
);

  logic       busy_q, busy_d;
  logic [4:0] mag_q, mag_d;
  logic [3:0] tens_q, tens_d;
  logic       neg_q, neg_d;

  assign done_o  = busy_q && (mag_q < 5'd10);
  assign tens_o  = tens_q;
  assign units_o = mag_q[3:0];
  assign neg_o   = neg_q;

  always_comb begin
    busy_d = busy_q;
    mag_d  = mag_q;
    tens_d = tens_q;
    neg_d  = neg_q;
    if (start_i) begin
      busy_d = 1'b1;
      mag_d  = abs_mag(value_i, signed_i);
      tens_d = 4'd0;
      neg_d  = signed_i & value_i[4];
    end else if (busy_q) begin
      if (done_o) begin
        busy_d = 1'b0;
      end else begin
        mag_d  = mag_q - 5'd10;
        tens_d = tens_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mag_q  <= '0;
      tens_q <= '0;
      neg_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      mag_q  <= mag_d;
      tens_q <= tens_d;
      neg_q  <= neg_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Accepts a value, converts it to digits, and scans units/tens/sign
// through one shared decoder with active-low anode enables.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_if.slave        bus,
  output logic [3:0]           digit,
  output logic [2:0]           an
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  conv_state_e state_q, state_d;
  logic        accept;
  logic        cv_done;
  logic [3:0]  cv_tens;
  logic [3:0]  cv_units;
  logic        cv_neg;

  logic [3:0]  units_q, units_d;
  logic [3:0]  tens_q, tens_d;
  logic        sign_q, sign_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  slot_e         slot_q, slot_d;
  logic [3:0]    digit_q, digit_d;
  logic [2:0]    an_q, an_d;

  assign bus.value_ready = (state_q == ST_IDLE);
  assign accept = bus.value_valid && bus.value_ready;
  assign digit  = digit_q;
  assign an     = an_q;

  bin2bcd_seq u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept),
    .value_i  (bus.value),
    .signed_i (bus.signed_mode),
    .done_o   (cv_done),
    .tens_o   (cv_tens),
    .units_o  (cv_units),
    .neg_o    (cv_neg)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)  state_d = ST_CONV;
      ST_CONV: if (cv_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // All three display registers move on the same edge
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    sign_d  = sign_q;
    if (cv_done) begin
      units_d = cv_units;
      tens_d  = (cv_tens == 4'd0) ? DIG_BLANK : cv_tens;
      sign_d  = cv_neg;
    end
  end

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Slot decisions use the display registers before any same-edge commit
  always_comb begin
    slot_d  = slot_q;
    digit_d = digit_q;
    an_d    = an_q;
    if (tick) begin
      unique case (slot_q)
        SLOT_UNITS: slot_d = SLOT_TENS;
        SLOT_TENS:  slot_d = sign_q ? SLOT_SIGN : SLOT_UNITS;
        default:    slot_d = SLOT_UNITS;
      endcase
      unique case (slot_d)
        SLOT_TENS: begin
          digit_d = tens_q;
          an_d    = AN_TENS;
        end
        SLOT_SIGN: begin
          digit_d = DIG_MINUS;
          an_d    = AN_SIGN;
        end
        default: begin
          digit_d = units_q;
          an_d    = AN_UNITS;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      units_q <= 4'd0;
      tens_q  <= DIG_BLANK;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      slot_q  <= SLOT_UNITS;
      digit_q <= 4'd0;
      an_q    <= AN_UNITS;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      an_q    <= an_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with SCAN_DIV=4.
// Directed scenarios plus random values against a cycle model.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic [2:0] an;

  display_scan_if bus ();

  display_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .digit (digit),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: shown digits, pending conversion, scan position
  int         m_units, m_tens, m_sign;
  int         m_busy, m_left;
  int         p_units, p_tens, p_sign;
  int         m_cnt, m_slot;
  logic [3:0] m_digit;
  logic [2:0] m_an;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_units = 0; m_tens = 0; m_sign = 0;
    m_busy = 0; m_left = 0;
    m_cnt = 0; m_slot = 0;
    m_digit = 4'd0; m_an = 3'b110;
  endtask

  task automatic model_edge();
    int v, mag;
    int rdy;
    rdy = !m_busy;
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      if (m_slot == 0)      m_slot = 1;
      else if (m_slot == 1) m_slot = m_sign ? 2 : 0;
      else                  m_slot = 0;
      case (m_slot)
        0: begin m_digit = 4'(m_units); m_an = 3'b110; end
        1: begin
          m_digit = (m_tens == 0) ? 4'hF : 4'(m_tens);
          m_an = 3'b101;
        end
        default: begin m_digit = 4'hA; m_an = 3'b011; end
      endcase
    end else begin
      m_cnt++;
    end
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_units = p_units; m_tens = p_tens; m_sign = p_sign;
        m_busy = 0;
      end
    end
    if (rdy && bus.value_valid) begin
      v = int'(bus.value);
      p_sign = (bus.signed_mode && v >= 16) ? 1 : 0;
      mag = p_sign ? 32 - v : v;
      p_tens = mag / 10;
      p_units = mag % 10;
      m_busy = 1;
      m_left = mag / 10 + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an", 8'(an), 8'(m_an));
    chk("digit", 8'(digit), 8'(m_digit));
    chk("ready", 8'(bus.value_ready), 8'(!m_busy));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [4:0] v, input logic sm);
    int mag, lows;
    bus.value = v;
    bus.signed_mode = sm;
    bus.value_valid = 1'b1;
    step();
    bus.value_valid = 1'b0;
    mag = (sm && v[4]) ? 32 - int'(v) : int'(v);
    lows = (bus.value_ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.value_ready) break;
      step();
      if (!bus.value_ready) lows++;
    end
    chk("ready_low_cycles", 8'(lows), 8'(mag / 10 + 1));
  endtask

  initial begin
    int found;
    rst_n = 1'b0;
    bus.value_valid = 1'b0;
    bus.value = '0;
    bus.signed_mode = 1'b0;
    model_reset();
    #12;
    chk("rst_an", 8'(an), 8'h06);
    chk("rst_digit", 8'(digit), 8'h00);
    chk("rst_ready", 8'(bus.value_ready), 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    steps(10);

    // Reset in the middle of converting 25
    bus.value = 5'd25;
    bus.signed_mode = 1'b0;
    bus.value_valid = 1'b1;
    step();
    bus.value_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midconv_rst_an", 8'(an), 8'h06);
    chk("midconv_rst_digit", 8'(digit), 8'h00);
    chk("midconv_rst_ready", 8'(bus.value_ready), 8'h01);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    steps(4);
    chk("post_rst_tens_an", 8'(an), 8'h05);
    chk("post_rst_tens_dig", 8'(digit), 8'h0F);
    steps(12);

    send(5'd31, 1'b0);
    steps(20);
    send(5'b10000, 1'b1);
    steps(20);
    send(5'b00111, 1'b1);
    steps(16);

    // Valid held: 12 accepted, 9 ignored until ready returns
    bus.value = 5'd12;
    bus.signed_mode = 1'b0;
    bus.value_valid = 1'b1;
    step();
    bus.value = 5'd9;
    steps(3);
    bus.value_valid = 1'b0;
    steps(16);

    // Commit of -5 lands on the tick leaving the TENS slot
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_slot == 1 && m_cnt == DIV - 2 && !m_busy) begin
        found = 1;
        break;
      end
      step();
    end
    chk("tens_tick_align", 8'(found), 8'h01);
    bus.value = 5'b11011;
    bus.signed_mode = 1'b1;
    bus.value_valid = 1'b1;
    step();
    bus.value_valid = 1'b0;
    step();
    chk("edge_commit_an", 8'(an), 8'h06);
    chk("edge_commit_dig", 8'(digit), 8'h09);
    steps(4);
    chk("neg5_tens_an", 8'(an), 8'h05);
    chk("neg5_tens_dig", 8'(digit), 8'h0F);
    steps(4);
    chk("neg5_sign_an", 8'(an), 8'h03);
    chk("neg5_sign_dig", 8'(digit), 8'h0A);
    steps(4);
    chk("neg5_units_dig", 8'(digit), 8'h05);

    for (int k = 0; k < 30; k++) begin
      send(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      steps($urandom_range(0, 12));
    end
    steps(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan controller for the two-digit-plus-sign 7-segment display. It accepts a 5-bit value through a valid/ready handshake and converts it to tens/units with a sequential repeated-subtraction loop. It then time-multiplexes the single shared BCD-to-7-segment decoder across the units, tens and sign digits, driving the active-low anode lines. It sits between the switch/value source and the decoder, replacing the free-running tick-driven digit sequencer.

## Interface
- SCAN_DIV, 50000, clock cycles per digit slot; minimum 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value_valid  in  1  new value offered.
- value_ready  out  1  controller can accept a value; high only in IDLE.
- value  in  5  value to display.
- signed_mode  in  1  sampled with value: 1 means two's complement (-16..15), 0 means unsigned (0..31).
- digit  out  4  code to the shared decoder: 0-9 are BCD digits, DIG_MINUS=4'hA, DIG_BLANK=4'hF.
- an  out  3  active-low digit enables: bit0 units, bit1 tens, bit2 sign.

## Operation
- Conversion FSM, states IDLE and CONV.
  - IDLE: value_ready=1. On value_valid&&value_ready, go to CONV.
    - Capture mag, which is -value when signed_mode&&value[4], else value. The width is 5 bits unsigned, so -16 gives 16.
    - Capture neg = signed_mode&value[4], set tens=0.
  - CONV: value_ready=0.
    - Each clock with mag>=10: mag-=10, tens+=1.
    - At the clock with mag<10: commit to the display registers and return to IDLE.
      - Committed values: units_d=mag; tens_d = tens, or DIG_BLANK if tens==0; sign_on=neg.
    - The commit is atomic. The display never shows partial results.
  - value_valid seen while value_ready=0 is ignored, not queued.
- Scan FSM, independent of the conversion FSM.
  - The prescaler counts 0..SCAN_DIV-1. scan_tick is asserted on the cycle it holds SCAN_DIV-1, and it then wraps to 0.
  - Slot order is UNITS -> TENS -> SIGN -> UNITS when sign_on=1, and UNITS -> TENS -> UNITS when sign_on=0.
  - On the scan_tick edge, the slot advances and the outputs are registered for the new slot:
    - UNITS: digit=units_d, an=3'b110.
    - TENS: digit=tens_d, an=3'b101.
    - SIGN: digit=DIG_MINUS, an=3'b011.
  - Exactly one an bit is low at all times after reset.
- Reset values, applied asynchronously:
  - Conversion FSM IDLE, value_ready=1.
  - units_d=0, tens_d=DIG_BLANK, sign_on=0.
  - Prescaler 0, slot UNITS, digit=4'd0, an=3'b110.
- Reset asserted mid-CONV discards the conversion in progress. The display returns to showing "0".

## Timing
- Accept edge E0. Commit occurs at edge E0+floor(mag/10)+1, so worst case (31, or -16 gives 16) is E0+4 and E0+2.
- value_ready is low from E0 through the commit edge and high in the cycle after the commit.
- A new digit/an is visible one cycle after scan_tick. Each slot lasts exactly SCAN_DIV cycles.
- Commit and scan_tick on the same edge: the slot advance uses the pre-commit units_d, tens_d and sign_on, including the TENS->SIGN decision. New values appear from the next scan_tick.
- When sign_on clears while the SIGN slot is active, the slot finishes and the next slot is UNITS.

## Structure
- Package display_pkg holds:
  - DIG_BLANK and DIG_MINUS.
  - AN_UNITS=3'b110, AN_TENS=3'b101, AN_SIGN=3'b011.
  - The slot enum (SLOT_UNITS, SLOT_TENS, SLOT_SIGN) and the conversion-state enum (ST_IDLE, ST_CONV).
- Natural sub-module: bin2bcd_seq. It holds the repeated-subtraction converter with start/done and outputs tens, units and neg. The top holds the handshake, display registers, prescaler and scan FSM.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset pulse mid-CONV (while converting 25) -> an=110, digit=0, value_ready=1; after release the scan alternates 110 (0) and 101 (F) every 4 cycles.
- Unsigned 31, signed_mode=0 -> ready low 4 cycles, commit; scan shows digit 1 with an=110, then 3 with an=101, and an=011 never appears.
- Signed 5'b10000 (-16) -> commit after 2 cycles; scan shows 6/110, 1/101, A/011, then repeats.
- Signed 5'b00111 (+7) -> commit after 1 cycle; scan shows 7/110, F/101, and no sign slot.
- value_valid held high with 12 then 9 -> 12 is accepted; valid while ready=0 is ignored; 9 is accepted the cycle after commit, and the final display is 9/F.
- Commit of -5 timed on a scan_tick edge while the TENS slot is active -> the next slot is UNITS showing the old value; the SIGN slot appears only on the following rotation.
